// File: rtl/rv32i_datapath.sv
// Single-cycle RV32I datapath: PC, 32x32 register file, immediate generator, ALU and muxes.
// Define DATAPATH_REGFILE_RESET_EN to have reset clear x1-x31; otherwise only pc is reset.
module rv32i_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic        regWE,
  input  logic        rs1sel,
  input  logic        rs2sel,
  input  logic [1:0]  regsel,
  input  logic [1:0]  PCsel,
  input  logic [2:0]  ImmSel,
  input  logic [3:0]  ALUControl,
  input  logic [31:0] Instr,
  input  logic [31:0] dmemData,
  output logic [31:0] pc,
  output logic [31:0] dmemrs2,
  output logic [31:0] ALUout
);

  localparam int DATA_W = 32;

  logic [4:0]        rs1, rs2, rd;
  logic [DATA_W-1:0] rs1_val, rs2_val, imm;
  logic [DATA_W-1:0] alu_a, alu_b, wb_data;
  logic [DATA_W-1:0] pc_plus4, pc_imm, pc_next;
  logic [DATA_W-1:0] rf [0:31];
  logic              unused_opcode;

  function automatic logic [DATA_W-1:0] gen_imm(input logic [31:0] ins,
                                                input logic [2:0]  sel);
    case (sel)
      3'b000:  return {ins[31:12], 12'b0};
      3'b001:  return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      3'b010:  return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      3'b011:  return {{20{ins[31]}}, ins[31:20]};
      3'b100:  return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      default: return '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] alu_op(input logic [3:0]               op,
                                               input logic signed [DATA_W-1:0] a,
                                               input logic signed [DATA_W-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a << sh;
      4'b0011: return {31'b0, a < b};
      4'b0100: return {31'b0, $unsigned(a) < $unsigned(b)};
      4'b0101: return a ^ b;
      4'b0110: return $unsigned(a) >> sh;
      4'b0111: return a >>> sh;
      4'b1000: return a | b;
      4'b1001: return a & b;
      4'b1010: return b;
      default: return '0;
    endcase
  endfunction

  assign rs1 = Instr[19:15];
  assign rs2 = Instr[24:20];
  assign rd  = Instr[11:7];
  assign unused_opcode = ^Instr[6:0];

  // x0 is never stored; the read mux supplies its zero
  assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];
  assign dmemrs2 = rs2_val;

  assign imm    = gen_imm(Instr, ImmSel);
  assign alu_a  = rs1sel ? pc  : rs1_val;
  assign alu_b  = rs2sel ? imm : rs2_val;
  assign ALUout = alu_op(ALUControl, alu_a, alu_b);

  assign pc_plus4 = pc + 32'd4;
  assign pc_imm   = pc + imm;

  always_comb begin
    wb_data = ALUout;
    case (regsel)
      2'b00: wb_data = ALUout;
      2'b01: wb_data = dmemData;
      2'b10: wb_data = imm;
      2'b11: wb_data = pc_plus4;
      default: wb_data = ALUout;
    endcase
  end

  always_comb begin
    pc_next = pc_plus4;
    case (PCsel)
      2'b00: pc_next = pc_plus4;
      2'b01: pc_next = pc_imm;
      2'b10: pc_next = {ALUout[31:1], 1'b0};
      2'b11: pc_next = pc;
      default: pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= '0;
    else        pc <= pc_next;
  end

`ifdef DATAPATH_REGFILE_RESET_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) rf[i] <= '0;
    end else if (regWE && rd != 5'd0) begin
      rf[rd] <= wb_data;
    end
  end
`else
  // No reset on the storage so it can map to RAM; reset still blocks the write
  always_ff @(posedge clk) begin
    if (reset && regWE && rd != 5'd0) rf[rd] <= wb_data;
  end
`endif

endmodule

// File: tb/tb_rv32i_datapath.sv
// Self-checking bench for rv32i_datapath: directed scenarios then randomized
// instructions compared against an architectural model of pc and x0-x31.
module tb_rv32i_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWE, rs1sel, rs2sel;
  logic [1:0]  regsel, PCsel;
  logic [2:0]  ImmSel;
  logic [3:0]  ALUControl;
  logic [31:0] Instr, dmemData;
  logic [31:0] pc, dmemrs2, ALUout;

  int checks = 0;
  int errors = 0;

  logic [31:0] mrf [32];
  logic [31:0] mpc;
  logic [31:0] obs_alu, obs_rs2;

  rv32i_datapath dut (
    .clk(clk), .reset(reset), .regWE(regWE), .rs1sel(rs1sel), .rs2sel(rs2sel),
    .regsel(regsel), .PCsel(PCsel), .ImmSel(ImmSel), .ALUControl(ALUControl),
    .Instr(Instr), .dmemData(dmemData), .pc(pc), .dmemrs2(dmemrs2), .ALUout(ALUout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_imm(input logic [31:0] ins, input logic [2:0] sel);
    logic [31:0] t;
    case (sel)
      3'd0: t = ins & 32'hFFFF_F000;
      3'd1: begin
        t = $signed(ins) >>> 11;
        t = (t & 32'hFFF0_0000) | (ins & 32'h000F_F000) | (32'(ins[20]) << 11)
            | (32'(ins[30:21]) << 1);
      end
      3'd2: begin
        t = $signed(ins) >>> 19;
        t = (t & 32'hFFFF_F000) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5)
            | (32'(ins[11:8]) << 1);
      end
      3'd3: t = $signed(ins) >>> 20;
      3'd4: begin
        t = $signed(ins) >>> 20;
        t = (t & ~32'h1F) | 32'(ins[11:7]);
      end
      default: t = 32'd0;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, b);
    int unsigned s;
    s = b % 32;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << s;
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> s;
      4'd7:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic we, input logic r1s, input logic r2s,
                      input logic [1:0] rsel, input logic [1:0] psel, input logic [2:0] isel,
                      input logic [3:0] aluc, input logic [31:0] dm);
    logic [31:0] im, a, b, res, wb, npc;
    @(negedge clk);
    Instr = ins; regWE = we; rs1sel = r1s; rs2sel = r2s; regsel = rsel; PCsel = psel;
    ImmSel = isel; ALUControl = aluc; dmemData = dm;
    #1;
    im  = m_imm(ins, isel);
    a   = r1s ? mpc : mrf[ins[19:15]];
    b   = r2s ? im  : mrf[ins[24:20]];
    res = m_alu(aluc, a, b);
    obs_alu = ALUout;
    obs_rs2 = dmemrs2;
    chk("aluout", ALUout, res);
    chk("dmemrs2", dmemrs2, mrf[ins[24:20]]);
    case (rsel)
      2'd0: wb = res;
      2'd1: wb = dm;
      2'd2: wb = im;
      default: wb = mpc + 4;
    endcase
    case (psel)
      2'd0: npc = mpc + 4;
      2'd1: npc = mpc + im;
      2'd2: npc = res - (res % 2);
      default: npc = mpc;
    endcase
    @(posedge clk);
    #1;
    mpc = npc;
    if (we && ins[11:7] != 5'd0) mrf[ins[11:7]] = wb;
    chk("pc", pc, mpc);
  endtask

  task automatic peek(input logic [4:0] r, input logic [31:0] exp, input string tag);
    @(negedge clk);
    Instr = {7'd0, r, 20'd0}; regWE = 1'b0; PCsel = 2'b11;
    #1;
    chk(tag, dmemrs2, exp);
  endtask

  initial begin
    logic [31:0] p, rnd, ins;
    logic [11:0] im12;
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    reset = 1'b1; regWE = 1'b0; rs1sel = 1'b0; rs2sel = 1'b0; regsel = 2'b00;
    PCsel = 2'b00; ImmSel = 3'b000; ALUControl = 4'd0; Instr = 32'd0; dmemData = 32'd0;

    // Reset and release
    #1 reset = 1'b0;
    #1 chk("reset_pc", pc, 32'd0);
`ifdef DATAPATH_REGFILE_RESET_EN
    for (int r = 1; r < 32; r++) begin
      Instr = {7'd0, 5'(r), 20'd0};
      #1 chk("reset_rf", dmemrs2, 32'd0);
    end
`endif
    @(negedge clk);
    PCsel = 2'b00; regWE = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1 chk("release_pc", pc, 32'd4);
    mpc = 32'd4;

    // Give every register a known value (ADDI xr, x0, imm with rs2 field = x0)
    for (int r = 1; r < 32; r++) begin
      rnd  = $urandom;
      im12 = {rnd[11:5], 5'd0};
      ins  = {im12, 5'd0, 3'b000, 5'(r), 7'h13};
      step(ins, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 3'b011, 4'd0, 32'd0);
    end

    // LUI x1
    p = mpc;
    step(32'h123450B7, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 3'b000, 4'd0, 32'd0);
    chk("lui_pc", pc, p + 32'd4);
    peek(5'd1, 32'h12345000, "lui_x1");
    // ADDI x2, x1, -1
    step(32'hFFF08113, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 3'b011, 4'd0, 32'd0);
    chk("addi_alu", obs_alu, 32'h12344FFF);
    peek(5'd2, 32'h12344FFF, "addi_x2");
    // ADDI x0, x1, 5
    step(32'h00508013, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 3'b011, 4'd0, 32'd0);
    peek(5'd0, 32'd0, "x0_guard");
    // LW x3, 8(x2)
    step(32'h00812183, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 3'b011, 4'd0, 32'hDEADBEEF);
    chk("load_addr", obs_alu, 32'h12345007);
    peek(5'd3, 32'hDEADBEEF, "load_x3");
    // SW x3, 0(x2)
    step(32'h00312023, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'b100, 4'd0, 32'd0);
    chk("store_data", obs_rs2, 32'hDEADBEEF);
    chk("store_addr", obs_alu, 32'h12344FFF);
    // JAL x1, +8
    p = mpc;
    step(32'h008000EF, 1'b1, 1'b0, 1'b1, 2'b11, 2'b01, 3'b001, 4'd0, 32'd0);
    chk("jal_pc", pc, p + 32'd8);
    peek(5'd1, p + 32'd4, "jal_link");
    // JALR x0, 0x105(x0)
    step(32'h10500067, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 3'b011, 4'd0, 32'd0);
    chk("jalr_alu", obs_alu, 32'h00000105);
    chk("jalr_pc", pc, 32'h00000104);
    // Jump to 0xFFFFFFFC, then pc+4 wraps to 0
    step(32'hFFC00067, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 3'b011, 4'd0, 32'd0);
    chk("wrap_top", pc, 32'hFFFFFFFC);
    step(32'h00000013, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'b011, 4'd0, 32'd0);
    chk("wrap_pc", pc, 32'd0);

    // Randomized instructions and controls
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom;
      step($urandom, rnd[0], rnd[1], rnd[2], rnd[4:3], rnd[6:5], rnd[9:7], rnd[13:10], $urandom);
    end

    // Reset asserted mid-cycle aborts the pending write to x5
    step({12'h120, 5'd0, 3'b000, 5'd5, 7'h13}, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 3'b011, 4'd0, 32'd0);
    @(negedge clk);
    Instr = {12'h7E0, 5'd0, 3'b000, 5'd5, 7'h13}; regWE = 1'b1; rs1sel = 1'b0; rs2sel = 1'b1;
    ImmSel = 3'b011; ALUControl = 4'd0; regsel = 2'b00; PCsel = 2'b00;
    #2 reset = 1'b0;
    #1 chk("rst_async_pc", pc, 32'd0);
    @(posedge clk);
    #1 chk("rst_hold_pc", pc, 32'd0);
`ifdef DATAPATH_REGFILE_RESET_EN
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
`endif
    @(negedge clk);
    regWE = 1'b0; PCsel = 2'b00; reset = 1'b1;
    @(posedge clk);
    #1 chk("rerelease_pc", pc, 32'd4);
    mpc = 32'd4;
    peek(5'd5, mrf[5], "rst_abort_x5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_datapath.md
# rv32i_datapath

Single-cycle RV32I datapath: program counter, 32×32 register file, immediate generator, ALU and the operand/write-back/next-PC multiplexers. It sits between the instruction memory (`pc` out, `Instr` in), the data memory (`ALUout` as address, `dmemrs2` as write data, `dmemData` as read data) and the control unit, which drives every select/enable input. The block has no decode logic of its own; all control arrives on the select inputs.

## Interface
- No parameters; XLEN fixed at 32.
- One clock; reset is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `regWE` in 1: register-file write enable.
- `rs1sel` in 1: ALU A select; 0 = rs1 value, 1 = `pc`.
- `rs2sel` in 1: ALU B select; 0 = rs2 value, 1 = immediate.
- `regsel` in 2: write-back select; 00 = `ALUout`, 01 = `dmemData`, 10 = immediate, 11 = `pc`+4.
- `PCsel` in 2: next-PC select; 00 = `pc`+4, 01 = `pc`+imm, 10 = `ALUout` & ~1, 11 = hold `pc`.
- `ImmSel` in 3: immediate format; 000 = U, 001 = J, 010 = B, 011 = I, 100 = S, others = 0.
- `ALUControl` in 4: ALU operation; see Operation.
- `Instr` in 32: current instruction.
- `dmemData` in 32: data-memory read data.
- `pc` out 32: current program counter.
- `dmemrs2` out 32: rs2 register value, used as store data.
- `ALUout` out 32: ALU result, also the data-memory address.

## Operation
- Instruction fields: rs1 = `Instr`[19:15], rs2 = [24:20], rd = [11:7].
- Register file: two combinational read ports and one synchronous write port. x0 always reads 0. Writes to rd = 0 are discarded.
- Immediates are formed per the RISC-V spec, all sign-extended from `Instr`[31]:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- ALUControl encodings (32-bit, wrap-around arithmetic, no flags):
  - 0000 ADD; 0001 SUB; 0010 SLL; 0011 SLT (signed); 0100 SLTU.
  - 0101 XOR; 0110 SRL; 0111 SRA; 1000 OR; 1001 AND; 1010 pass B.
  - All other codes give 0.
  - Shift amount is B[4:0].
- `pc`+4 and `pc`+imm are computed by dedicated adders, independent of the ALU. Both wrap modulo 2^32.
- Branch decisions are made by the control unit from `ALUout` (SUB, SLT, SLTU results); the block exports no comparison flags.

## Timing
- Single-cycle; every output is combinational from current state and inputs, except `pc`.
- On the rising edge of `clk`:
  - `pc` ← next-PC mux.
  - If `regWE`=1 and rd≠0: x[rd] ← write-back mux.
- A register read in the same cycle as a write to that register returns the old value; the new value is visible after the edge.
- `reset` low asynchronously forces `pc` = 0x00000000 and, when the Configuration macro is defined, x1–x31 = 0. While `reset` is low, all writes and PC updates are ignored.
- Reset release is synchronised by the system; the first update occurs on the first rising edge with `reset` high.
- Reset asserted mid-cycle aborts the pending write.

## Configuration
- `DATAPATH_REGFILE_RESET_EN` defined: reset clears x1–x31 to 0.
- `DATAPATH_REGFILE_RESET_EN` undefined: reset affects only `pc`; register contents are undefined until written, which allows a RAM-inferred register file.
- x0 reads 0 in both builds.

## Test plan
- **Reset:** `reset`=0 with the macro defined → `pc`=0; x1–x31 read 0. Release `reset` with PCsel=00 → `pc`=4 after one edge.
- **LUI:** `Instr`=0x123450B7, regWE=1, regsel=10, ImmSel=000 → after edge x1=0x12345000, `pc` advanced by 4.
- **ADDI:** `Instr`=0xFFF08113, rs1sel=0, rs2sel=1, ImmSel=011, ALUControl=0000, regsel=00 → `ALUout`=0x12344FFF, then x2=0x12344FFF.
- **x0 guard:** ADDI x0,x1,5 (`Instr`=0x00508013) with regWE=1 → x0 still reads 0.
- **Load/store path:** rs2sel=1, ImmSel=011, regsel=01, `dmemData`=0xDEADBEEF → `ALUout`=rs1+imm and rd=0xDEADBEEF after edge. With ImmSel=100, `dmemrs2` equals the rs2 register value.
- **Jumps:**
  - JAL (`Instr`=0x008000EF, PCsel=01, ImmSel=001, regsel=11) at `pc`=P → `pc`=P+8 and x1=P+4.
  - JALR with `ALUout`=0x00000105 and PCsel=10 → `pc`=0x00000104.
